// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM states and the bundled hazard-control word.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned HZ_CNT_W       = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic ex_hold;
    logic exm_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_DEFAULT = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b0,
    idex_bubble: 1'b0,
    ex_hold:     1'b0,
    exm_bubble:  1'b0
  };

endpackage

// File: rtl/hazard_stall_controller.sv
// Load-use stall, taken-branch flush and multi-cycle multiply freeze for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_ifid,
  input  logic [REG_ADDR_W-1:0] rs2_ifid,
  input  logic                  uses_rs1_ifid,
  input  logic                  uses_rs2_ifid,
  input  logic [REG_ADDR_W-1:0] rd_idex,
  input  logic                  memread_idex,
  input  logic                  mul_start_idex,
  input  logic                  branch_taken_ex,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  ex_hold,
  output logic                  exm_bubble,
  output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  if (MUL_LATENCY < 2 || MUL_LATENCY > 15) begin : g_bad_latency
    $error("hazard_stall_controller: MUL_LATENCY must be in 2..15");
  end

  localparam logic [HZ_CNT_W-1:0] CNT_LOAD = HZ_CNT_W'(MUL_LATENCY - 1);

  hz_state_t             r_state;
  hz_state_t             w_state_nxt;
  logic [HZ_CNT_W-1:0]   r_cnt;
  logic [HZ_CNT_W-1:0]   w_cnt_nxt;
  hz_ctrl_t              w_ctrl;
  logic                  w_busy;
  logic                  w_lu;

  assign w_lu = memread_idex && (rd_idex != '0) &&
                ((uses_rs1_ifid && (rd_idex == rs1_ifid)) ||
                 (uses_rs2_ifid && (rd_idex == rs2_ifid)));

  // Next state, counter and control outputs; reset forces the default control word.
  always_comb begin
    w_ctrl      = HZ_CTRL_DEFAULT;
    w_busy      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (branch_taken_ex) begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
        end else if (mul_start_idex) begin
          w_ctrl.pc_write   = 1'b0;
          w_ctrl.ifid_write = 1'b0;
          w_ctrl.ex_hold    = 1'b1;
          w_ctrl.exm_bubble = 1'b1;
          w_state_nxt       = MUL_BUSY;
          w_cnt_nxt         = CNT_LOAD;
        end else if (w_lu) begin
          w_ctrl.pc_write    = 1'b0;
          w_ctrl.ifid_write  = 1'b0;
          w_ctrl.idex_bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (r_cnt > HZ_CNT_W'(1)) begin
          w_busy            = 1'b1;
          w_ctrl.pc_write   = 1'b0;
          w_ctrl.ifid_write = 1'b0;
          w_ctrl.ex_hold    = 1'b1;
          w_ctrl.exm_bubble = 1'b1;
          w_cnt_nxt         = r_cnt - HZ_CNT_W'(1);
        end else begin
          // Release cycle: EX still owns the multiply, so only load-use is honoured.
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          if (w_lu) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.ifid_write  = 1'b0;
            w_ctrl.idex_bubble = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!rst_n) begin
      w_ctrl = HZ_CTRL_DEFAULT;
      w_busy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc_write    = w_ctrl.pc_write;
  assign ifid_write  = w_ctrl.ifid_write;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_bubble = w_ctrl.idex_bubble;
  assign ex_hold     = w_ctrl.ex_hold;
  assign exm_bubble  = w_ctrl.exm_bubble;
  assign busy        = w_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_ctrl.pc_write)  r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_ctrl.ifid_flush) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed vector table plus randomized run vs. a model.
module tb_hazard_stall_controller;

  localparam int unsigned L  = 4;
  localparam int unsigned AW = 5;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exm_bubble, busy}
  localparam logic [6:0] E_DEF  = 7'b1100000;
  localparam logic [6:0] E_LU   = 7'b0001000;
  localparam logic [6:0] E_BR   = 7'b1111000;
  localparam logic [6:0] E_MULS = 7'b0000110;
  localparam logic [6:0] E_MULB = 7'b0000111;

  typedef struct {
    logic          rst_n;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          mr;
    logic          mul;
    logic          br;
    logic [6:0]    exp;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1_ifid, rs2_ifid, rd_idex;
  logic          uses_rs1_ifid, uses_rs2_ifid, memread_idex, mul_start_idex, branch_taken_ex;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exm_bubble, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  hazard_stall_controller #(.MUL_LATENCY(L), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .uses_rs1_ifid(uses_rs1_ifid), .uses_rs2_ifid(uses_rs2_ifid),
    .rd_idex(rd_idex), .memread_idex(memread_idex),
    .mul_start_idex(mul_start_idex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ex_hold(ex_hold), .exm_bubble(exm_bubble), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input int rs1v, input int rs2v, input logic u1v,
                              input logic u2v, input int rdv, input logic mrv, input logic mulv,
                              input logic brv, input logic [6:0] e);
    vec_t v;
    v.rst_n = r; v.rs1 = AW'(rs1v); v.rs2 = AW'(rs2v); v.u1 = u1v; v.u2 = u2v;
    v.rd = AW'(rdv); v.mr = mrv; v.mul = mulv; v.br = brv; v.exp = e;
    return v;
  endfunction

  // Drive one cycle, compare at the falling edge, then track counters across the rising edge.
  task automatic do_cycle(input vec_t v, input string tag, input int idx);
    logic [6:0] got;
    rst_n = v.rst_n; rs1_ifid = v.rs1; rs2_ifid = v.rs2; uses_rs1_ifid = v.u1;
    uses_rs2_ifid = v.u2; rd_idex = v.rd; memread_idex = v.mr;
    mul_start_idex = v.mul; branch_taken_ex = v.br;
    @(negedge clk);
    got = {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exm_bubble, busy};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s[%0d] ctrl: got %b expected %b", tag, idx, got, v.exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== exp_stall || flush_count !== exp_flush) begin
      errors++;
      $display("FAIL %s[%0d] perf: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               tag, idx, stall_cycles, flush_count, exp_stall, exp_flush);
    end
`endif
    @(posedge clk);
    if (!v.rst_n) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!v.exp[6]) exp_stall++;
      if (v.exp[4])  exp_flush++;
    end
    #1;
  endtask

  // Model: mul_age = which EX cycle the multiply is in (0 = no multiply in EX).
  int mul_age = 0;

  function automatic logic [6:0] model_expect(input vec_t v);
    logic lu;
    lu = v.mr && (v.rd != 0) && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
    if (!v.rst_n) return E_DEF;
    if (mul_age == 0) begin
      if (v.br)  return E_BR;
      if (v.mul) return E_MULS;
      if (lu)    return E_LU;
      return E_DEF;
    end
    if (mul_age < int'(L)) return E_MULB;
    return lu ? E_LU : E_DEF;
  endfunction

  function automatic void model_step(input vec_t v);
    if (!v.rst_n)                 mul_age = 0;
    else if (mul_age == 0)        mul_age = (!v.br && v.mul) ? 2 : 0;
    else if (mul_age >= int'(L))  mul_age = 0;
    else                          mul_age = mul_age + 1;
  endfunction

  vec_t tbl[24];

  initial begin
    tbl[0]  = mk(0, 3, 3, 1, 1, 3, 1, 1, 1, E_DEF);   // reset forces defaults
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF);
    tbl[3]  = mk(1, 5, 0, 1, 0, 5, 1, 0, 0, E_LU);    // load-use on rs1
    tbl[4]  = mk(1, 1, 2, 1, 1, 3, 0, 0, 0, E_DEF);
    tbl[5]  = mk(1, 0, 0, 1, 1, 0, 1, 0, 0, E_DEF);   // rd=0 never stalls
    tbl[6]  = mk(1, 7, 7, 0, 1, 7, 1, 0, 0, E_LU);    // load-use on rs2
    tbl[7]  = mk(1, 9, 9, 0, 0, 9, 1, 0, 0, E_DEF);   // match but not used
    tbl[8]  = mk(1, 5, 0, 1, 0, 5, 1, 0, 1, E_BR);    // branch beats load-use
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, E_BR);    // branch beats multiply
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULS);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULB);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULB);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_DEF);   // release ignores mul
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULS);  // back-to-back, no gap
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULB);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, E_MULB);  // branch ignored while busy
    tbl[17] = mk(1, 5, 0, 1, 0, 5, 1, 1, 1, E_LU);    // LU in release cycle
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULS);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULB);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_DEF);   // reset mid-multiply
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF);
    tbl[23] = mk(1, 4, 0, 1, 0, 4, 1, 0, 0, E_LU);

    rst_n = 1'b0; rs1_ifid = '0; rs2_ifid = '0; rd_idex = '0;
    uses_rs1_ifid = 1'b0; uses_rs2_ifid = 1'b0; memread_idex = 1'b0;
    mul_start_idex = 1'b0; branch_taken_ex = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) do_cycle(tbl[i], "table", i);

    // Hand sequence: reset during a multiply leaves busy low and perf counters cleared.
    do_cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULS), "rst_seq", 0);
    do_cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MULB), "rst_seq", 1);
    do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF),  "rst_seq", 2);
    do_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF),  "rst_seq", 3);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL rst_seq stall_cycles: got %0d expected 0", stall_cycles);
    end
`endif

    mul_age = 0;
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v.rst_n = ($urandom_range(0, 99) >= 2);
      v.rs1   = AW'($urandom_range(0, 3));
      v.rs2   = AW'($urandom_range(0, 3));
      v.rd    = AW'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.mr    = ($urandom_range(0, 9) < 4);
      v.mul   = ($urandom_range(0, 9) < 2);
      v.br    = ($urandom_range(0, 9) < 2);
      v.exp   = model_expect(v);
      do_cycle(v, "random", i);
      model_step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
